// File: rtl/jtag_shift_pkg.sv
// Shared types and default parameters for the JTAG shift engine.
// Optional feature macro: JTAG_SHIFT_TRST_EN (adds the TRST state).
package jtag_shift_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_CHAINS = 2;
    localparam int DEF_DIV_W      = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOW  = 3'd1,
        HIGH = 3'd2,
        RESP = 3'd3
`ifdef JTAG_SHIFT_TRST_EN
        , TRST = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/jtag_clk_div.sv
// TCK half-period counter: counts 0..div, tc marks the last cycle of a phase.
// load parks the counter at 0 between commands; pause freezes it.
module jtag_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             pause,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = (cnt == div);

    // phase counter, wraps to 0 on terminal count
    always_ff @(posedge clk) begin
        if (!reset)      cnt <= '0;
        else if (load)   cnt <= '0;
        else if (!pause) cnt <= tc ? '0 : cnt + DIV_W'(1);
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: shifts up to DATA_W TMS/TDI bits LSB first onto one of
// NUM_CHAINS chains and returns the captured TDO bits as a response.
// Optional feature macro: JTAG_SHIFT_TRST_EN (per-chain TRST pulse before shifting).
module jtag_shift_engine
    import jtag_shift_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int DIV_W      = DEF_DIV_W,
    localparam int LEN_W     = $clog2(DATA_W + 1),
    localparam int CH_W      = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  init_done,
    input  logic [DIV_W-1:0]      div,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [CH_W-1:0]       cmd_chain,
    input  logic [DATA_W-1:0]     cmd_tms,
    input  logic [DATA_W-1:0]     cmd_tdi,
`ifdef JTAG_SHIFT_TRST_EN
    input  logic                  cmd_trst,
    output logic [NUM_CHAINS-1:0] jtag_TRST,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_tdo,
    output logic [NUM_CHAINS-1:0] jtag_TCK,
    output logic [NUM_CHAINS-1:0] jtag_TMS,
    output logic [NUM_CHAINS-1:0] jtag_TDI,
    input  logic [NUM_CHAINS-1:0] jtag_TDO
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t                  state_q, state_d;
    logic [1:0]              rst_pipe;
    logic [DATA_W-1:0]       tms_q, tdi_q, tdo_q;
    logic [LEN_W-1:0]        len_q, len_c;
    logic [CH_W-1:0]         chain_q;
    logic [DIV_W-1:0]        div_q;
    logic [IDX_W-1:0]        bit_q;
    logic [NUM_CHAINS-1:0]   chain_hit;
    logic                    run, armed, accept, active, shifting, last, div_tc, tdo_sel;
`ifdef JTAG_SHIFT_TRST_EN
    logic                    trst_ph;
`endif

    assign run      = enable & init_done;
    assign armed    = (&rst_pipe) & run;
    assign accept   = cmd_valid & cmd_ready;
    assign len_c    = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
    assign shifting = (state_q == LOW) || (state_q == HIGH);
`ifdef JTAG_SHIFT_TRST_EN
    assign active   = shifting || (state_q == TRST);
`else
    assign active   = shifting;
`endif
    assign last     = (LEN_W'(bit_q) + LEN_W'(1)) == len_q;
    assign tdo_sel  = |(jtag_TDO & chain_hit);

    // one-hot decode of the latched chain number
    always_comb begin
        for (int c = 0; c < NUM_CHAINS; c++) chain_hit[c] = (chain_q == CH_W'(c));
    end

    jtag_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .load  (!active),
        .pause (!run),
        .div   (div_q),
        .tc    (div_tc)
    );

    // reset must be released for two edges before commands are taken
    always_ff @(posedge clk) begin
        if (!reset) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic; run low freezes every timed state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
`ifdef JTAG_SHIFT_TRST_EN
                if (cmd_trst) state_d = TRST;
                else
`endif
                if (len_c == '0) state_d = RESP;
                else             state_d = LOW;
            end
            LOW:  if (run && div_tc) state_d = HIGH;
            HIGH: if (run && div_tc) state_d = last ? RESP : LOW;
            RESP: if (rsp_ready) state_d = IDLE;
`ifdef JTAG_SHIFT_TRST_EN
            TRST: if (run && div_tc && trst_ph) state_d = (len_q == '0) ? RESP : LOW;
`endif
            default: state_d = IDLE;
        endcase
    end

    // command latch, TDO capture on the TCK rising edge, bit advance on falling
    always_ff @(posedge clk) begin
        if (!reset) begin
            tms_q   <= '0;
            tdi_q   <= '0;
            tdo_q   <= '0;
            len_q   <= '0;
            chain_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
`ifdef JTAG_SHIFT_TRST_EN
            trst_ph <= 1'b0;
`endif
        end else if (accept) begin
            tms_q   <= cmd_tms;
            tdi_q   <= cmd_tdi;
            tdo_q   <= '0;
            len_q   <= len_c;
            chain_q <= cmd_chain;
            div_q   <= div;
            bit_q   <= '0;
`ifdef JTAG_SHIFT_TRST_EN
            trst_ph <= 1'b0;
`endif
        end else if (run && div_tc) begin
            case (state_q)
                LOW:  tdo_q[bit_q] <= tdo_sel;
                HIGH: bit_q <= bit_q + IDX_W'(1);
`ifdef JTAG_SHIFT_TRST_EN
                TRST: trst_ph <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // outputs decoded from state; everything forced low while in reset
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_tdo   = '0;
        jtag_TCK  = '0;
        jtag_TMS  = '0;
        jtag_TDI  = '0;
`ifdef JTAG_SHIFT_TRST_EN
        jtag_TRST = '0;
`endif
        if (reset) begin
            cmd_ready = armed && (state_q == IDLE);
            rsp_valid = (state_q == RESP);
            rsp_tdo   = (state_q == RESP) ? tdo_q : '0;
            for (int c = 0; c < NUM_CHAINS; c++) begin
                if (chain_hit[c]) begin
                    jtag_TCK[c]  = (state_q == HIGH);
                    jtag_TMS[c]  = shifting && tms_q[bit_q];
                    jtag_TDI[c]  = shifting && tdi_q[bit_q];
`ifdef JTAG_SHIFT_TRST_EN
                    jtag_TRST[c] = (state_q == TRST);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: expected TDO words are queued at
// command issue and compared when the response handshake completes.
// Exercises the TRST path when JTAG_SHIFT_TRST_EN is defined.
module tb_jtag_shift_engine;

    localparam int DATA_W     = 32;
    localparam int NUM_CHAINS = 2;
    localparam int DIV_W      = 8;
    localparam int LEN_W      = $clog2(DATA_W + 1);
    localparam int CH_W       = 1;

    logic                  clk = 1'b0;
    logic                  reset, enable, init_done;
    logic [DIV_W-1:0]      div;
    logic                  cmd_valid, cmd_ready;
    logic [LEN_W-1:0]      cmd_len;
    logic [CH_W-1:0]       cmd_chain;
    logic [DATA_W-1:0]     cmd_tms, cmd_tdi;
    logic                  rsp_valid, rsp_ready;
    logic [DATA_W-1:0]     rsp_tdo;
    logic [NUM_CHAINS-1:0] jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
`ifdef JTAG_SHIFT_TRST_EN
    logic                  cmd_trst;
    logic [NUM_CHAINS-1:0] jtag_TRST;
`endif

    int          n_tests = 0, n_fail = 0, pulses = 0, rsp_cnt = 0;
    logic [63:0] tdo_pat = 64'hD;
    logic [63:0] exp_q[$];
    wire         tck_any = |jtag_TCK;

    assign jtag_TDO = {NUM_CHAINS{tdo_pat[pulses[5:0]]}};

    jtag_shift_engine #(.DATA_W(DATA_W), .NUM_CHAINS(NUM_CHAINS), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .init_done(init_done), .div(div),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_chain(cmd_chain), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
`ifdef JTAG_SHIFT_TRST_EN
        .cmd_trst(cmd_trst), .jtag_TRST(jtag_TRST),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
    );

    always #5 clk = ~clk;

    always @(posedge tck_any) pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_tdo(input logic [63:0] pat, input int len);
        int l = (len > DATA_W) ? DATA_W : len;
        return (l >= 64) ? pat : (pat & ((64'd1 << l) - 64'd1));
    endfunction

    // scoreboard: compare on the cycle the response handshake completes
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
            else                   chk("rsp_tdo", 64'(rsp_tdo), exp_q.pop_front());
            rsp_cnt++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // issue one command; returns with the first post-accept cycle visible
    task automatic send(input int len, input int ch, input logic [63:0] tms,
                        input logic [63:0] tdi, input int dv, input bit trst);
        int t = 0;
        while (!cmd_ready && t < 200) begin step(); t++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_chain = CH_W'(ch);
        cmd_tms   = tms[DATA_W-1:0];
        cmd_tdi   = tdi[DATA_W-1:0];
        div       = DIV_W'(dv);
`ifdef JTAG_SHIFT_TRST_EN
        cmd_trst  = trst;
`else
        if (trst) $display("note: trst request ignored in this build");
`endif
        exp_q.push_back(exp_tdo(tdo_pat, len));
        pulses = 0;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (!rsp_valid && t < 2000) begin step(); t++; end
        chk("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v8, tmsv, tdiv;
        logic [5:0]  v6;
        logic [2:0]  snap;
        logic [DATA_W-1:0] held;
        logic        c0act;
        int          rc;

        reset = 1'b0; enable = 1'b1; init_done = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b0; cmd_len = '0; cmd_chain = '0; cmd_tms = '0; cmd_tdi = '0; div = '0;
`ifdef JTAG_SHIFT_TRST_EN
        cmd_trst = 1'b0;
`endif
        repeat (3) step();
        chk("reset_ready", 64'(cmd_ready), 64'd0);
        chk("reset_outs", 64'({rsp_valid, jtag_TCK, jtag_TMS, jtag_TDI}), 64'd0);
        chk("reset_tdo", 64'(rsp_tdo), 64'd0);
        reset = 1'b1;
        step();
        chk("arm_delay", 64'(cmd_ready), 64'd0);
        step();
        chk("armed", 64'(cmd_ready), 64'd1);

        // shift: div=0, len=4, TDO 1,0,1,1 -> 0xD
        tdo_pat = 64'hD;
        send(4, 0, 64'h3, 64'hA, 0, 1'b0);
        v8 = '0; tmsv = '0; tdiv = '0;
        for (int c = 1; c <= 8; c++) begin
            v8[c-1] = jtag_TCK[0];
            if (c % 2 == 1) begin
                tmsv[(c-1)/2] = jtag_TMS[0];
                tdiv[(c-1)/2] = jtag_TDI[0];
            end
            if (c < 8) step();
        end
        chk("shift_rsp_early", 64'(rsp_valid), 64'd0);
        step();
        chk("shift_rsp_c9", 64'(rsp_valid), 64'd1);
        chk("shift_tck", 64'(v8), 64'hAA);
        chk("shift_tms", 64'(tmsv[3:0]), 64'h3);
        chk("shift_tdi", 64'(tdiv[3:0]), 64'hA);
        chk("shift_pulses", 64'(pulses), 64'd4);
        step();

        // divider: div=2, len=1; div changed mid-command is ignored
        send(1, 0, 64'h1, 64'h1, 2, 1'b0);
        v6 = '0;
        for (int c = 1; c <= 6; c++) begin
            v6[c-1] = jtag_TCK[0];
            if (c == 2) div = '0;
            step();
        end
        chk("div_tck", 64'(v6), 64'h38);
        chk("div_rsp", 64'(rsp_valid), 64'd1);
        step();

        // zero length, then over-length clamp
        send(0, 0, 64'hF, 64'hF, 0, 1'b0);
        chk("zero_rsp", 64'(rsp_valid), 64'd1);
        chk("zero_pulses", 64'(pulses), 64'd0);
        step();
        tdo_pat = {$urandom, $urandom};
        send(40, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);
        wait_rsp();
        chk("clamp_pulses", 64'(pulses), 64'd32);
        step();

        // freeze during bit 2 of a len=8 command
        tdo_pat = {$urandom, $urandom};
        send(8, 0, 64'h5A, 64'hC7, 0, 1'b0);
        repeat (4) step();
        enable = 1'b0;
        snap = {jtag_TCK[0], jtag_TMS[0], jtag_TDI[0]};
        chk("freeze_bit2", 64'(snap), 64'b001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("freeze_outs", 64'({jtag_TCK[0], jtag_TMS[0], jtag_TDI[0]}), 64'(snap));
        end
        chk("freeze_pulses", 64'(pulses), 64'd2);
        enable = 1'b1;
        wait_rsp();
        chk("freeze_total", 64'(pulses), 64'd8);
        step();
        init_done = 1'b0; #1;
        chk("init_low_ready", 64'(cmd_ready), 64'd0);
        init_done = 1'b1; #1;
        chk("init_high_ready", 64'(cmd_ready), 64'd1);

        // backpressure on chain 1; chain 0 must stay quiet
        tdo_pat = {$urandom, $urandom};
        rsp_ready = 1'b0;
        c0act = 1'b0;
        send(5, 1, 64'h1F, 64'h15, 1, 1'b0);
        for (int t = 0; t < 100 && !rsp_valid; t++) begin
            c0act |= jtag_TCK[0] | jtag_TMS[0] | jtag_TDI[0];
            step();
        end
        chk("bp_rsp", 64'(rsp_valid), 64'd1);
        chk("chain0_quiet", 64'(c0act), 64'd0);
        chk("chain1_pulses", 64'(pulses), 64'd5);
        held = rsp_tdo;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_tdo", 64'(rsp_tdo), 64'(held));
            chk("bp_ready", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        step();

        // reset mid-command: outputs drop, no response
        send(8, 0, 64'hFF, 64'hFF, 1, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("abort_outs", 64'({cmd_ready, rsp_valid, jtag_TCK, jtag_TMS, jtag_TDI}), 64'd0);
        void'(exp_q.pop_back());
        rc = rsp_cnt;
        reset = 1'b1;
        step();
        chk("abort_arm_delay", 64'(cmd_ready), 64'd0);
        step();
        chk("abort_rearmed", 64'(cmd_ready), 64'd1);
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(rc));

`ifdef JTAG_SHIFT_TRST_EN
        // TRST pulse: div=1 -> 4 cycles ahead of the first LOW
        send(1, 0, 64'h1, 64'h1, 1, 1'b1);
        cmd_trst = 1'b0;
        v6 = '0; v8 = '0;
        for (int c = 1; c <= 5; c++) begin
            v6[c-1] = jtag_TRST[0];
            v8[c-1] = jtag_TCK[0];
            step();
        end
        chk("trst_pulse", 64'(v6), 64'h0F);
        chk("trst_tck_low", 64'(v8), 64'd0);
        wait_rsp();
        step();
`endif

        step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
